// File: rtl/addr_addsub_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  addr_addsub_pipe_pkg
//  Shared constants for the address add/subtract functional unit.
//
//  Contents:
//    OP_AADD / OP_ASUB  opcode values (Aj+Ak, Aj-Ak)
//    A_WIDTH            default address operand width
//    A_TAG_W            A-register destination index width (A0-A7)
//    is_legal_op()      true for opcodes this unit executes
//
//  Revision: 1.0  initial release
// ============================================================================
package addr_addsub_pipe_pkg;

  localparam logic [6:0] OP_AADD = 7'o030;
  localparam logic [6:0] OP_ASUB = 7'o031;
  localparam int         A_WIDTH = 24;
  localparam int         A_TAG_W = 3;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_AADD) || (op == OP_ASUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_pipe_stage.sv
`default_nettype none
// ============================================================================
//  addr_pipe_stage
//  One delay stage of the address pipe: a valid bit plus an opaque payload.
//  The valid bit is cleared by asynchronous reset or synchronous flush; the
//  payload follows the previous stage unconditionally (don't-care when the
//  valid bit is low).
//
//  Ports:
//    clk         in   clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    flush       in   clear the valid bit at this edge
//    prev_valid  in   valid bit from the preceding stage
//    prev_data   in   payload from the preceding stage
//    valid       out  registered valid bit
//    data        out  registered payload
//
//  Revision: 1.0  initial release
// ============================================================================
module addr_pipe_stage
  import addr_addsub_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = A_WIDTH + A_TAG_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 prev_valid,
  input  logic [PAYLOAD_W-1:0] prev_data,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= prev_valid & ~flush;
      data  <= prev_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/addr_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  addr_addsub_pipe
//  Fully pipelined address add/subtract unit (opcodes 030 Aj+Ak, 031 Aj-Ak).
//  One issue per clock, result STAGES clocks after issue, no backpressure.
//  Stage 1 performs the add; the remaining STAGES-1 stages are pure delay.
//
//  Ports:
//    clk, rst_n   clock (rising edge) / asynchronous active-low reset
//    i_valid      issue strobe, operands sampled on this edge
//    i_instr      7-bit opcode
//    i_aj, i_ak   operands (WIDTH bits)
//    i_tag        destination A-register index
//    i_flush      kill every in-flight operation (and a same-edge issue)
//    o_valid      one-cycle pulse per completed operation
//    o_result     sum/difference modulo 2^WIDTH
//    o_carry      carry out of MSB (subtract: 1 = no borrow)
//    o_tag        destination of o_result
//    o_illegal    one-cycle pulse after a valid issue with bad opcode
//    o_busy       any stage holds a valid operation
//
//  Revision: 1.0  initial release
// ============================================================================
module addr_addsub_pipe
  import addr_addsub_pipe_pkg::*;
#(
  parameter int WIDTH  = A_WIDTH,
  parameter int STAGES = 2,
  parameter int TAG_W  = A_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [6:0]       i_instr,
  input  logic [WIDTH-1:0] i_aj,
  input  logic [WIDTH-1:0] i_ak,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_illegal,
  output logic             o_busy
);

  // Payload layout: {tag, carry, result}
  localparam int PAYLOAD_W = TAG_W + 1 + WIDTH;

  logic             legal;
  logic             is_sub;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH:0]   sum;

  // Subtract is Aj + ~Ak + 1, so the carry-out doubles as "no borrow".
  always_comb begin
    legal     = is_legal_op(i_instr);
    is_sub    = (i_instr == OP_ASUB);
    operand_b = is_sub ? ~i_ak : i_ak;
    sum       = {1'b0, i_aj} + {1'b0, operand_b} + {{WIDTH{1'b0}}, is_sub};
  end

  logic                 s1_valid;
  logic [PAYLOAD_W-1:0] s1_data;
  logic                 illegal;

  // Illegal reporting is independent of flush: the issue is refused either way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      illegal  <= 1'b0;
    end else begin
      s1_valid <= i_valid & legal & ~i_flush;
      s1_data  <= {i_tag, sum};
      illegal  <= i_valid & ~legal;
    end
  end

  logic [STAGES-1:0]    valid_pipe;
  logic [PAYLOAD_W-1:0] data_pipe [STAGES];

  assign valid_pipe[0] = s1_valid;
  assign data_pipe[0]  = s1_data;

  generate
    for (genvar k = 1; k < STAGES; k++) begin : g_delay
      addr_pipe_stage #(
        .PAYLOAD_W (PAYLOAD_W)
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (i_flush),
        .prev_valid (valid_pipe[k-1]),
        .prev_data  (data_pipe[k-1]),
        .valid      (valid_pipe[k]),
        .data       (data_pipe[k])
      );
    end
  endgenerate

  assign o_valid                     = valid_pipe[STAGES-1];
  assign {o_tag, o_carry, o_result}  = data_pipe[STAGES-1];
  assign o_illegal                   = illegal;
  assign o_busy                      = |valid_pipe;

endmodule
`default_nettype wire
